parity_frame_tx: RTL and testbench



---
 rtl/parity_frame_pkg.sv | 16 +
 rtl/bit_timer.sv | 32 +++
 rtl/parity_frame_tx.sv | 113 +++++++++++
 tb/tb_parity_frame_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and line levels for the parity frame transmitter.
package parity_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Serial bit timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count_q, count_d;

    assign bit_end = (count_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || bit_end) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Frames a data word plus its upstream parity bit as start, data (LSB first),
// parity and stop bits on a single serial line.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             parity_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               parity_q, parity_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tx_q, tx_d;
    logic               busy_q;
    logic               bit_end;
    logic               timer_clear;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        idx_d       = idx_q;
        timer_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Holding the timer at 0 in idle makes the start bit full length.
                timer_clear = 1'b1;
                if (in_valid) begin
                    shift_d  = data_in;
                    parity_d = parity_in;
                    idx_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(WIDTH - 1)) state_d = StParity;
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is computed from the next state so tx_out is a plain flop.
    always_comb begin
        tx_d = LINE_IDLE;
        unique case (state_d)
            StStart:  tx_d = START_BIT;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            StStop:   tx_d = STOP_BIT;
            default:  tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    // Decoded only from flops (state and timer count), never from the inputs.
    assign frame_done = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: directed and random frames at CLKS_PER_BIT 4 and 1,
// compared against a bit-list model of the frame.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] data_in;
    logic       parity_in;
    logic       v4, v1;
    logic       tx4, rdy4, busy4, done4;
    logic       tx1, rdy1, busy1, done1;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.WIDTH(10), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_in(parity_in),
        .in_valid(v4), .in_ready(rdy4), .tx_out(tx4), .busy(busy4), .frame_done(done4)
    );

    parity_frame_tx #(.WIDTH(10), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_in(parity_in),
        .in_valid(v1), .in_ready(rdy1), .tx_out(tx1), .busy(busy1), .frame_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int cpb, input string tag);
        chk({tag, " tx"},    (cpb == 4) ? tx4   : tx1,   1);
        chk({tag, " ready"}, (cpb == 4) ? rdy4  : rdy1,  1);
        chk({tag, " busy"},  (cpb == 4) ? busy4 : busy1, 0);
        chk({tag, " done"},  (cpb == 4) ? done4 : done1, 0);
    endtask

    // Called at a negedge with the selected DUT idle. Sends d/p, then checks the
    // whole frame and the idle cycle after it. nd/np replace the inputs mid-frame.
    task automatic frame(input int cpb, input logic [9:0] d, input logic p, input bit hold,
                         input logic [9:0] nd, input logic np);
        logic line[$];
        logic bits[$];
        int   total;
        bits.push_back(1'b0);
        for (int i = 0; i < 10; i++) bits.push_back(d[i]);
        bits.push_back(p);
        bits.push_back(1'b1);
        foreach (bits[b]) for (int r = 0; r < cpb; r++) line.push_back(bits[b]);
        total = line.size();
        chk("ready before accept", (cpb == 4) ? rdy4 : rdy1, 1);
        data_in = d; parity_in = p;
        if (cpb == 4) v4 = 1'b1; else v1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin v4 = 1'b0; v1 = 1'b0; end
        data_in = nd; parity_in = np;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            chk($sformatf("tx c%0d d%03h", k, d), (cpb == 4) ? tx4 : tx1, line[k]);
            chk($sformatf("busy c%0d", k), (cpb == 4) ? busy4 : busy1, 1);
            chk($sformatf("ready c%0d", k), (cpb == 4) ? rdy4 : rdy1, 0);
            chk($sformatf("done c%0d", k), (cpb == 4) ? done4 : done1, (k == total - 1));
        end
        @(negedge clk);
        chk_idle(cpb, "post-frame idle");
    endtask

    initial begin
        logic [9:0] d;
        logic       p;
        rst_n = 1'b0; data_in = '0; parity_in = 1'b0; v4 = 1'b0; v1 = 1'b0;

        // Reset and idle hold
        repeat (3) @(negedge clk);
        chk_idle(4, "in reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle(4, "idle cpb4");
            chk_idle(1, "idle cpb1");
        end

        // Single frame and odd parity passthrough
        frame(4, 10'b0101001001, 1'b0, 1'b0, 10'h2AA, 1'b1);
        @(negedge clk);
        frame(4, 10'h3FF, 1'b1, 1'b0, 10'h000, 1'b0);
        @(negedge clk);

        // Back-to-back with valid held; inputs changed during frame 1
        frame(4, 10'h001, 1'b0, 1'b1, 10'h200, 1'b1);
        frame(4, 10'h200, 1'b1, 1'b0, 10'h155, 1'b0);

        // Random words and parity with random idle gaps
        for (int n = 0; n < 4; n++) begin
            d = 10'($urandom);
            p = 1'($urandom);
            frame(4, d, p, 1'b0, 10'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk_idle(4, "random gap");
            end
        end

        // Asynchronous reset during data bit 5
        d = 10'h3A5;
        data_in = d; parity_in = 1'b1; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (26) @(negedge clk);
        chk("tx before reset", tx4, d[5]);
        #2 rst_n = 1'b0;
        #1;
        chk("tx in async reset", tx4, 1);
        chk("busy in async reset", busy4, 0);
        chk("ready in async reset", rdy4, 1);
        @(negedge clk);
        rst_n = 1'b1;
        frame(4, 10'h0F3, 1'b0, 1'b0, 10'h000, 1'b1);

        // One clock per bit
        @(negedge clk);
        frame(1, 10'h155, 1'b0, 1'b0, 10'h0AA, 1'b1);
        for (int n = 0; n < 3; n++) begin
            frame(1, 10'($urandom), 1'($urandom), 1'b0, 10'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
